// File: rtl/tile_line_renderer.sv
// Scanline-prefetching tile renderer: fills the next line into one bank of a
// double-buffered line store while the other bank is displayed. Optional colour keying via TILE_COLORKEY_EN.
module tile_line_renderer #(
  parameter int unsigned TILE_LOG2  = 2,
  parameter int unsigned LINE_W     = 480,
  parameter int unsigned V_LINES    = 272,
  parameter int unsigned COORD_W    = 9,
  parameter int unsigned TILE_NO_W  = 4,
  parameter int unsigned ROM_ADDR_W = 9,
  parameter int unsigned RGB_W      = 24,
  parameter logic [RGB_W-1:0] COLOR_KEY = 24'hFF00FF
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_line_start,
  input  logic [COORD_W-1:0]           i_y,
  input  logic [COORD_W-1:0]           i_x,
  input  logic                         i_de,
  input  logic [1:0]                   i_mirror,
  input  logic [1:0]                   i_rotate,
  output logic [COORD_W-TILE_LOG2-1:0] o_map_tile_x,
  output logic [COORD_W-TILE_LOG2-1:0] o_map_tile_y,
  input  logic [TILE_NO_W-1:0]         i_map_tile_no,
  output logic                         o_rom_read,
  output logic [ROM_ADDR_W-1:0]        o_rom_address,
  input  logic [RGB_W-1:0]             i_rom_data,
  input  logic                         i_rom_valid,
`ifdef TILE_COLORKEY_EN
  input  logic [RGB_W-1:0]             i_key_color,
`endif
  output logic [RGB_W-1:0]             o_rgb,
  output logic                         o_busy,
  output logic                         o_underrun
);

  localparam int unsigned TX_W  = COORD_W - TILE_LOG2;
  localparam int unsigned IDX_W = $clog2(LINE_W);
  localparam int unsigned FX_W  = IDX_W + 1;
  localparam int unsigned MEM_D = 2 ** (IDX_W + 1);

  typedef enum logic [1:0] {IDLE, MAP, REQ, NEXT} state_t;

  state_t                 state;
  logic                   bank_sel;
  logic [COORD_W-1:0]     target;
  logic [FX_W-1:0]        fill_x;
  logic [TILE_NO_W-1:0]   tile_no;
  logic [1:0]             mirror_q;
  logic [1:0]             rotate_q;
  logic [RGB_W-1:0]       line_mem [MEM_D];

  logic [COORD_W-1:0]     next_target_c;
  logic                   wr_en_c;
  logic [RGB_W-1:0]       wr_data_c;

  // Source texel address after mirroring the destination and rotating clockwise.
  function automatic logic [ROM_ADDR_W-1:0] src_addr(
    input logic [TILE_NO_W-1:0] tile,
    input logic [COORD_W-1:0]   tgt,
    input logic [FX_W-1:0]      fx,
    input logic [1:0]           mir,
    input logic [1:0]           rot
  );
    logic [TILE_LOG2-1:0] r, c, sr, sc;
    r = tgt[TILE_LOG2-1:0];
    c = fx[TILE_LOG2-1:0];
    if (mir[0]) c = ~c;
    if (mir[1]) r = ~r;
    case (rot)
      2'd0:    begin sr = r;  sc = c;  end
      2'd1:    begin sr = ~c; sc = r;  end
      2'd2:    begin sr = ~r; sc = ~c; end
      default: begin sr = c;  sc = ~r; end
    endcase
    return ROM_ADDR_W'({tile, sr, sc});
  endfunction

  always_comb begin
    next_target_c = (i_y == COORD_W'(V_LINES - 1)) ? '0 : i_y + COORD_W'(1);
    wr_en_c       = (state == REQ) && i_rom_valid && !i_line_start;
`ifdef TILE_COLORKEY_EN
    wr_data_c     = (i_rom_data == COLOR_KEY) ? i_key_color : i_rom_data;
`else
    wr_data_c     = i_rom_data;
`endif
  end

`ifndef TILE_COLORKEY_EN
  logic unused_key;
  assign unused_key = ^COLOR_KEY;
`endif

  // Fill sequencer: MAP lookup per tile, one ROM request per pixel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      bank_sel      <= 1'b0;
      target        <= '0;
      fill_x        <= '0;
      tile_no       <= '0;
      mirror_q      <= '0;
      rotate_q      <= '0;
      o_map_tile_x  <= '0;
      o_map_tile_y  <= '0;
      o_rom_read    <= 1'b0;
      o_rom_address <= '0;
      o_busy        <= 1'b0;
      o_underrun    <= 1'b0;
    end else begin
      o_underrun <= 1'b0;
      if (i_line_start) begin
        o_underrun   <= o_busy;
        bank_sel     <= ~bank_sel;
        target       <= next_target_c;
        fill_x       <= '0;
        mirror_q     <= i_mirror;
        rotate_q     <= i_rotate;
        o_map_tile_x <= '0;
        o_map_tile_y <= TX_W'(next_target_c >> TILE_LOG2);
        o_rom_read   <= 1'b0;
        o_busy       <= 1'b1;
        state        <= MAP;
      end else begin
        case (state)
          IDLE: ;
          MAP: begin
            tile_no       <= i_map_tile_no;
            o_rom_address <= src_addr(i_map_tile_no, target, fill_x, mirror_q, rotate_q);
            o_rom_read    <= 1'b1;
            state         <= REQ;
          end
          REQ: begin
            if (i_rom_valid) begin
              o_rom_read <= 1'b0;
              fill_x     <= fill_x + FX_W'(1);
              state      <= NEXT;
            end
          end
          NEXT: begin
            if (fill_x == FX_W'(LINE_W)) begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end else if (fill_x[TILE_LOG2-1:0] == '0) begin
              o_map_tile_x <= TX_W'(fill_x >> TILE_LOG2);
              o_map_tile_y <= TX_W'(target >> TILE_LOG2);
              state        <= MAP;
            end else begin
              o_rom_address <= src_addr(tile_no, target, fill_x, mirror_q, rotate_q);
              o_rom_read    <= 1'b1;
              state         <= REQ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Line store write port (fill bank); contents are not reset.
  always_ff @(posedge i_clk) begin
    if (wr_en_c) line_mem[{~bank_sel, IDX_W'(fill_x)}] <= wr_data_c;
  end

  // Display read port, one cycle latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rgb <= '0;
    end else if (i_de && (i_x < COORD_W'(LINE_W))) begin
      o_rgb <= line_mem[{bank_sel, IDX_W'(i_x)}];
    end else begin
      o_rgb <= '0;
    end
  end

endmodule
